// File: rtl/int_ctrl.sv
// int_ctrl: latches rising-edge requests from four sources, masks them, and issues one
// non-nesting interrupt pulse at a time. Optional irq_in synchronizer: define INT_CTRL_SYNC_EN.
module int_ctrl #(
  parameter logic [5:0]  RET_OP  = 6'b010000,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq_in,
  input  logic [5:0] op,
  input  logic       mask_we,
  input  logic [3:0] mask_data,
  output logic       interrupt,
  output logic [1:0] int_cause,
  output logic       in_service,
  output logic [3:0] pending
);

  localparam int unsigned CntW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StService, StHold} state_e;

  state_e            r_state;
  logic              r_interrupt;
  logic [1:0]        r_cause;
  logic              r_in_service;
  logic [3:0]        r_pending;
  logic [3:0]        r_mask;
  logic [3:0]        r_s_d;
  logic [CntW-1:0]   r_cnt;

  state_e            w_state_nxt;
  logic              w_int_nxt;
  logic [1:0]        w_cause_nxt;
  logic              w_insvc_nxt;
  logic [CntW-1:0]   w_cnt_nxt;
  logic [3:0]        w_clear;
  logic [3:0]        w_s;
  logic [3:0]        w_edge;
  logic [3:0]        w_eligible;
  logic [1:0]        w_winner;
  logic [3:0]        w_pend_nxt;

`ifdef INT_CTRL_SYNC_EN
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = irq_in;
`endif

  assign w_edge     = w_s & ~r_s_d;
  assign w_eligible = r_pending & ~r_mask;

  // Lowest eligible index wins.
  always_comb begin
    w_winner = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_eligible[i]) w_winner = 2'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_int_nxt   = 1'b0;
    w_cause_nxt = r_cause;
    w_insvc_nxt = r_in_service;
    w_cnt_nxt   = r_cnt;
    w_clear     = '0;
    unique case (r_state)
      StIdle: begin
        if (w_eligible != '0) begin
          w_state_nxt       = StIssue;
          w_int_nxt         = 1'b1;
          w_cause_nxt       = w_winner;
          w_clear[w_winner] = 1'b1;
          w_insvc_nxt       = 1'b1;
        end
      end
      StIssue: begin
        w_state_nxt = StService;
      end
      StService: begin
        if (op == RET_OP) begin
          w_state_nxt = StHold;
          w_insvc_nxt = 1'b0;
          w_cnt_nxt   = CntW'(HOLDOFF);
        end
      end
      StHold: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt <= CntW'(1)) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // A new edge on the winner in the same cycle as its clear keeps the bit set.
  assign w_pend_nxt = (r_pending & ~w_clear) | w_edge;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_interrupt  <= 1'b0;
      r_cause      <= 2'd0;
      r_in_service <= 1'b0;
      r_pending    <= 4'b0000;
      r_mask       <= 4'b1111;
      r_s_d        <= 4'b0000;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_interrupt  <= w_int_nxt;
      r_cause      <= w_cause_nxt;
      r_in_service <= w_insvc_nxt;
      r_pending    <= w_pend_nxt;
      r_s_d        <= w_s;
      r_cnt        <= w_cnt_nxt;
      if (mask_we) r_mask <= mask_data;
    end
  end

  assign interrupt  = r_interrupt;
  assign int_cause  = r_cause;
  assign in_service = r_in_service;
  assign pending    = r_pending;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed scenarios followed by random traffic, all checked against a
// request/service model of the interrupt controller.
module tb_int_ctrl;

  localparam logic [5:0]  RET  = 6'b010000;
  localparam int unsigned HOLD = 2;
`ifdef INT_CTRL_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  localparam int LAT = SYNC ? 4 : 2;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic [3:0] irq_in    = 4'b0000;
  logic [5:0] op        = 6'd0;
  logic       mask_we   = 1'b0;
  logic [3:0] mask_data = 4'b0000;
  logic       interrupt;
  logic [1:0] int_cause;
  logic       in_service;
  logic [3:0] pending;

  int_ctrl #(
    .RET_OP (RET),
    .HOLDOFF(HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .op        (op),
    .mask_we   (mask_we),
    .mask_data (mask_data),
    .interrupt (interrupt),
    .int_cause (int_cause),
    .in_service(in_service),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: requests, mask, "busy" (an ISR is running) and the post-ret wait in cycles.
  logic [3:0] m_pend, m_mask, m_s_d, m_h0, m_h1;
  logic       m_int, m_busy;
  logic [1:0] m_cause;
  int         m_wait;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = 4'b1111; m_s_d = '0; m_h0 = '0; m_h1 = '0;
    m_int = 1'b0; m_busy = 1'b0; m_cause = 2'd0; m_wait = 0;
  endtask

  task automatic model_step();
    logic [3:0] s, e, elig, np;
    logic       iss, rt;
    int         w;
    s    = SYNC ? m_h1 : irq_in;
    e    = s & ~m_s_d;
    elig = m_pend & ~m_mask;
    iss  = !m_busy && (m_wait == 0) && (elig != 0);
    // ret is ignored on the cycle the pulse is still high
    rt   = m_busy && !m_int && (op == RET);
    np   = m_pend;
    if (iss) begin
      w = 0;
      for (int i = 3; i >= 0; i--) if (elig[i]) w = i;
      m_cause = 2'(w);
      np[w]   = 1'b0;
      m_busy  = 1'b1;
    end else if (rt) begin
      m_busy = 1'b0;
      m_wait = HOLD;
    end else if (m_wait > 0) begin
      m_wait--;
    end
    m_int  = iss;
    m_pend = np | e;
    if (mask_we) m_mask = mask_data;
    m_s_d = s;
    m_h1  = m_h0;
    m_h0  = irq_in;
  endtask

  task automatic compare_all();
    check("interrupt", 32'(interrupt), 32'(m_int));
    check("int_cause", 32'(int_cause), 32'(m_cause));
    check("in_service", 32'(in_service), 32'(m_busy));
    check("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_int(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!interrupt && n < 20);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_int"}, 32'(interrupt), 32'd0);
    check({tag, "_svc"}, 32'(in_service), 32'd0);
    check({tag, "_cause"}, 32'(int_cause), 32'd0);
    check({tag, "_pend"}, 32'(pending), 32'd0);
  endtask

  task automatic finish_isr();
    op = RET;
    step();
    op = 6'd0;
    repeat (HOLD + 1) step();
  endtask

  initial begin
    int n;
    int pulses;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;

    // 1: masked request latches; unmasking issues it.
    irq_in = 4'b0100;
    repeat (4) step();
    check("s1_pend", 32'(pending), 32'h4);
    check("s1_noint", 32'(interrupt), 32'd0);
    mask_we = 1'b1; mask_data = 4'b0000;
    step();
    mask_we = 1'b0;
    step();
    check("s1_int", 32'(interrupt), 32'd1);
    check("s1_cause", 32'(int_cause), 32'd2);
    check("s1_pend0", 32'(pending), 32'd0);
    check("s1_svc", 32'(in_service), 32'd1);
    irq_in = 4'b0000;
    step();
    finish_isr();

    // 2: simultaneous requests, lower index first, second after holdoff.
    irq_in = 4'b1010;
    wait_int(n);
    check("s2_cause1", 32'(int_cause), 32'd1);
    irq_in = 4'b0000;
    step();
    op = RET;
    step();
    op = 6'd0;
    wait_int(n);
    check("s2_gap", 32'(n), 32'(HOLD + 1));
    check("s2_cause3", 32'(int_cause), 32'd3);
    step();
    finish_isr();

    // 3: repeated edges during service collapse into one request.
    irq_in = 4'b0100;
    wait_int(n);
    irq_in = 4'b0000;
    step();
    repeat (3) begin
      irq_in = 4'b0001; step();
      irq_in = 4'b0000; step();
    end
    repeat (3) step();
    op = RET;
    step();
    op = 6'd0;
    wait_int(n);
    check("s3_gap", 32'(n), 32'(HOLD + 1));
    check("s3_cause", 32'(int_cause), 32'd0);
    step();
    finish_isr();
    pulses = 0;
    repeat (10) begin
      step();
      if (interrupt) pulses++;
    end
    check("s3_single", 32'(pulses), 32'd0);

    // 4: ret in IDLE and during ISSUE is ignored.
    op = RET;
    repeat (3) step();
    irq_in = 4'b0010;
    wait_int(n);
    irq_in = 4'b0000;
    step();
    check("s4_issue_ret", 32'(in_service), 32'd1);
    step();
    check("s4_svc_ret", 32'(in_service), 32'd0);
    op = 6'd0;
    repeat (HOLD + 1) step();

    // 5: asynchronous reset mid-service with a pending request.
    irq_in = 4'b0100;
    wait_int(n);
    irq_in = 4'b1000;
    step();
    irq_in = 4'b0000;
    repeat (4) step();
    check("s5_pend", 32'(pending), 32'h8);
    #3 reset = 1'b0;
    #1;
    check_zero("s5_async");
    reset = 1'b1;
    model_reset();
    irq_in = 4'b1000;
    repeat (6) step();
    check("s5_masked", 32'(pending), 32'h8);
    mask_we = 1'b1; mask_data = 4'b0000;
    step();
    mask_we = 1'b0;
    step();
    check("s5_unmask", 32'(interrupt), 32'd1);
    irq_in = 4'b0000;
    step();
    finish_isr();

    // 6: request-to-pulse latency.
    repeat (3) step();
    irq_in = 4'b0100;
    wait_int(n);
    check("s6_latency", 32'(n), 32'(LAT));
    irq_in = 4'b0000;
    step();
    finish_isr();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      irq_in  = irq_in ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      op      = ($urandom_range(0, 3) == 0) ? RET : 6'($urandom);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_data = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      step();
      if ($urandom_range(0, 299) == 0) begin
        #3 reset = 1'b0;
        #1;
        check_zero("rnd_reset");
        reset = 1'b1;
        model_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt request controller that drives the `interrupt` input of the jump control block. It latches edge-triggered requests from up to four sources, applies a mask, and picks the highest-priority unmasked request. It issues a single-cycle interrupt pulse, then holds off further requests until the ISR's `ret` opcode is seen, because the jump control block has only one return-address/flag save slot and nesting is therefore not allowed. It sits beside the jump control block, sharing the same `op` bus and clock.

## Interface
- `RET_OP`, 6'b010000: opcode that ends an ISR; must match the jump control block's `ret` decode.
- `HOLDOFF`, 2: number of cycles (≥1) after `ret` is accepted before another pulse may issue. It covers the flag/address restore in the jump control block.
- `clk` in 1: system clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset. 0 = reset.
- `irq_in` in 4: request lines, rising-edge triggered. Bit 0 has the highest priority.
- `op` in 6: opcode on the same stage that feeds the jump control block.
- `mask_we` in 1: mask write strobe.
- `mask_data` in 4: new mask value. Bit = 1 masks that source.
- `interrupt` out 1: registered one-cycle pulse to the jump control block.
- `int_cause` out 2: index of the source being serviced.
- `in_service` out 1: high from the pulse until `ret` is accepted.
- `pending` out 4: latched, not-yet-serviced requests.

## Operation
- Edge detect:
  - `edge[i] = s[i] & ~s_d[i]`, where `s` is the (optionally synchronized) `irq_in` and `s_d` is its one-cycle delay.
  - `edge[i]` sets `pending[i]`.
- Masking:
  - A masked source still sets `pending`; it is only excluded from arbitration.
  - A `mask_we` write takes effect from the next cycle.
  - Unmasking a source that is already pending makes it eligible immediately in the following arbitration.
- Arbitration: `eligible = pending & ~mask`. The winner is the lowest set index.
- FSM states: IDLE, ISSUE, SERVICE, HOLD.
  - IDLE: if `eligible != 0`, go to ISSUE. On that edge:
    - register `interrupt` = 1;
    - load `int_cause` = winner;
    - clear `pending[winner]`.
  - ISSUE: lasts exactly one cycle. `interrupt` returns to 0 and the FSM goes to SERVICE. `op == RET_OP` is ignored here.
  - SERVICE: `in_service` = 1. When `op == RET_OP` is sampled, go to HOLD and load the counter with `HOLDOFF`.
  - HOLD: decrement the counter each cycle. Return to IDLE when it reaches 1, so HOLD lasts exactly `HOLDOFF` cycles.
- Boundary conditions:
  - `in_service` is high in ISSUE and SERVICE.
  - `int_cause` holds its value through SERVICE and HOLD. It changes only on the next issue.
  - If an edge on the winner arrives on the same cycle its pending bit is cleared, the set wins and the bit stays 1.
  - New edges during ISSUE, SERVICE or HOLD are latched and served after HOLD completes.
  - Repeated edges on an already pending source collapse into a single request.
  - `op == RET_OP` in IDLE or HOLD has no effect.
- Reset (asynchronous, any state, including mid-service):
  - FSM returns to IDLE;
  - `interrupt`, `in_service`, `int_cause` = 0;
  - `pending` = 4'b0000;
  - mask = 4'b1111 (all sources masked);
  - edge and synchronizer registers = 0, and the HOLD counter = 0.

## Timing
- The `interrupt` pulse is exactly 1 cycle wide. It never occurs while `in_service` is already high.
- Request latency, with `irq_in` first seen high at rising edge E1:
  - without the synchronizer, `pending` sets after E1 and `interrupt` is high after E2;
  - with the synchronizer, `pending` sets after E3 and `interrupt` is high after E4.
- If `ret` is sampled at edge K, `in_service` falls after K. The earliest next `interrupt` is high after edge K+`HOLDOFF`+1.
- The mask write at edge M is used for arbitration at edge M+1.

## Configuration
- `INT_CTRL_SYNC_EN`:
  - Defined: `irq_in` passes through a two-flop synchronizer before edge detection, for asynchronous external sources. Latency is 4 edges.
  - Undefined: `irq_in` feeds the edge detector directly and must be synchronous to `clk`. Latency is 2 edges.

## Test plan
1. Reset release, mask 4'b1111, `irq_in[2]` rises → `pending` = 4'b0100, no `interrupt`. Then write mask 4'b0000 → single `interrupt` pulse, `int_cause` = 2, `pending` = 0, `in_service` = 1.
2. Mask 0, `irq_in[3]` and `irq_in[1]` rise on the same cycle → first pulse with `int_cause` = 1. Drive `op` = 6'b010000 → after `HOLDOFF`+1 edges a second pulse with `int_cause` = 3.
3. While in SERVICE, drive `irq_in[0]` rising edges three times → exactly one further pulse after `ret`. No pulse occurs before `ret`.
4. `op` = 6'b010000 held during ISSUE and in IDLE → no state change. `in_service` drops only on a `ret` sampled in SERVICE.
5. Assert `reset` = 0 mid-SERVICE with `pending` = 4'b1000 → outputs 0, `pending` = 0, mask = 4'b1111 immediately (asynchronous, before the next clock edge). No pulse after release until unmasked and a new edge arrives.
6. Run scenario 1 with and without `INT_CTRL_SYNC_EN` → `interrupt` high after edge E4 and after edge E2 respectively.
